// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder driving one external 4-bit adder a nibble per cycle, carry chained in a register.
// Latency NIBBLES+1 cycles start-to-done; i_start is dropped (not queued) while busy or done.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [4*NIBBLES-1:0] i_op_a,
    input  logic [4*NIBBLES-1:0] i_op_b,
    input  logic                 i_cin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [4*NIBBLES-1:0] o_sum,
    output logic                 o_cout,
    output logic                 o_ovf,
    output logic [3:0]           o_add_a,
    output logic [3:0]           o_add_b,
    output logic                 o_add_ci,
    input  logic [3:0]           i_add_s,
    input  logic                 i_add_co
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            ovf_q;
    logic            busy_q;
    logic            done_q;
    logic            last_nib;

    assign last_nib = (idx_q == IW'(NIBBLES - 1));
    assign idx_d    = idx_q + IW'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        a_q     <= i_op_a;
                        b_q     <= i_op_b;
                        carry_q <= i_cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[4*idx_q +: 4] <= i_add_s;
                    carry_q             <= i_add_co;
                    if (last_nib) begin
                        // Carry into the MSB is recovered from the MSB sum bit and its operands.
                        cout_q  <= i_add_co;
                        ovf_q   <= a_q[W-1] ^ b_q[W-1] ^ i_add_s[3] ^ i_add_co;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_add_a  = 4'd0;
        o_add_b  = 4'd0;
        o_add_ci = 1'b0;
        if (state_q == RUN) begin
            o_add_a  = a_q[4*idx_q +: 4];
            o_add_b  = b_q[4*idx_q +: 4];
            o_add_ci = carry_q;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_sum  = sum_q;
    assign o_cout = cout_q;
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with NIBBLES=4 and a behavioural 4-bit adder.
module tb_nibble_serial_adder_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_ci;
    logic [3:0]  add_s;
    logic        add_co;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_cin    (cin),
        .o_busy   (busy),
        .o_done   (done),
        .o_sum    (sum),
        .o_cout   (cout),
        .o_ovf    (ovf),
        .o_add_a  (add_a),
        .o_add_b  (add_b),
        .o_add_ci (add_ci),
        .i_add_s  (add_s),
        .i_add_co (add_co)
    );

    // Stand-in for the external four_bit_adder.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic [15:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
        int n;
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = 16'hDEAD;
        op_b  = 16'hBEEF;
        cin   = ~c;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_add_a0"}, {28'd0, add_a}, {28'd0, a[3:0]});
        chk({tag, "_add_ci0"}, {31'd0, add_ci}, {31'd0, c});
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 32'd4);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        tick();
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_flags", {30'd0, cout, ovf}, 32'd0);
        chk("rst_adder", {23'd0, add_a, add_b, add_ci}, 32'd0);
        tick();

        // First nibble: 4+D = 0x11, so nibble 0 is 1 with carry into nibble 1.
        op_a  = 16'h1234;
        op_b  = 16'h0FCD;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("part_sum", {16'd0, sum}, 32'h0001);
        chk("part_add", {23'd0, add_a, add_b, add_ci}, {23'd0, 4'h3, 4'hC, 1'b1});
        repeat (4) tick();
        tick();

        run_add("v1", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        run_add("v2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_add("v3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_add("v4", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        chk("idle_adder", {23'd0, add_a, add_b, add_ci}, 32'd0);

        // Start request during RUN must be dropped.
        op_a  = 16'h0001;
        op_b  = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        op_a  = 16'h1111;
        op_b  = 16'h1111;
        ndone = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("ign_done_cnt", ndone, 32'd1);
        chk("ign_sum", {16'd0, sum}, 32'h0002);
        chk("ign_busy", {31'd0, busy}, 32'd0);

        // Reset on the second RUN cycle abandons the add.
        op_a  = 16'h00FF;
        op_b  = 16'h0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_sum", {16'd0, sum}, 32'd0);
        chk("mrst_adder", {23'd0, add_a, add_b, add_ci}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("mrst_no_done", ndone, 32'd0);
        run_add("v5", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
